// File: rtl/mat3_stream_engine.sv
// Streaming NxN matrix engine: loads A then B, computes A*B, A+B or A-B with one
// shared multiply-accumulate, and streams the result out row-major.
module mat3_stream_engine #(
   parameter int W = 17,
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   op_i,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int NN = N * N;
   localparam int BW = ($clog2(2 * NN) > 0) ? $clog2(2 * NN) : 1;
   localparam int IW = ($clog2(NN) > 0) ? $clog2(NN) : 1;
   localparam int CW = ($clog2(N) > 0) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_CALC = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic [BW-1:0]  r_beat;
   logic [CW-1:0]  r_i;
   logic [CW-1:0]  r_j;
   logic [CW-1:0]  r_k;
   logic [IW-1:0]  r_e;
   logic [IW-1:0]  r_idx;
   logic [W-1:0]   r_acc;
   logic [1:0]     r_op;

   logic           r_in_ready;
   logic           r_out_valid;
   logic [W-1:0]   r_out_data;
   logic           r_out_last;
   logic           r_busy;

   logic [W-1:0]   r_mat_a [NN];
   logic [W-1:0]   r_mat_b [NN];
   logic [W-1:0]   r_mat_r [NN];

   logic           w_in_fire;
   logic           w_out_fire;
   logic           w_load_last;
   logic           w_is_add;
   logic           w_is_sub;
   logic           w_is_mul;
   logic           w_i_last;
   logic           w_j_last;
   logic           w_k_last;
   logic           w_e_last;
   logic           w_calc_done;
   logic [IW-1:0]  w_a_idx;
   logic [IW-1:0]  w_b_idx;
   logic [IW-1:0]  w_r_idx;
   logic [IW-1:0]  w_idx_inc;
   logic [W-1:0]   w_prod;
   logic [W-1:0]   w_sum;
   logic [W-1:0]   w_addsub;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign busy      = r_busy;

   assign w_in_fire   = in_valid && r_in_ready;
   assign w_out_fire  = r_out_valid && out_ready;
   assign w_load_last = (r_beat == BW'(2 * NN - 1));
   assign w_is_add    = (r_op == 2'b01);
   assign w_is_sub    = (r_op == 2'b10);
   assign w_is_mul    = !(w_is_add || w_is_sub);
   assign w_i_last    = (r_i == CW'(N - 1));
   assign w_j_last    = (r_j == CW'(N - 1));
   assign w_k_last    = (r_k == CW'(N - 1));
   assign w_e_last    = (r_e == IW'(NN - 1));
   assign w_calc_done = w_is_mul ? (w_i_last && w_j_last && w_k_last) : w_e_last;

   assign w_a_idx   = IW'(r_i * N + r_k);
   assign w_b_idx   = IW'(r_k * N + r_j);
   assign w_r_idx   = IW'(r_i * N + r_j);
   assign w_idx_inc = r_idx + IW'(1);

   // Truncated products and sums are identical for signed and unsigned operands
   assign w_prod   = r_mat_a[w_a_idx] * r_mat_b[w_b_idx];
   assign w_sum    = ((r_k == {CW{1'b0}}) ? {W{1'b0}} : r_acc) + w_prod;
   assign w_addsub = w_is_sub ? (r_mat_a[r_e] - r_mat_b[r_e]) : (r_mat_a[r_e] + r_mat_b[r_e]);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD: begin
            if (w_in_fire && w_load_last) begin
               w_state_nxt = S_CALC;
            end else begin
               w_state_nxt = S_LOAD;
            end
         end
         S_CALC: begin
            if (w_calc_done) begin
               w_state_nxt = S_OUT;
            end else begin
               w_state_nxt = S_CALC;
            end
         end
         S_OUT: begin
            if (w_out_fire && r_out_last) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_state_nxt = S_OUT;
            end
         end
         default: w_state_nxt = S_LOAD;
      endcase
   end

   // Counters, accumulator, op latch and registered stream outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat      <= {BW{1'b0}};
         r_i         <= {CW{1'b0}};
         r_j         <= {CW{1'b0}};
         r_k         <= {CW{1'b0}};
         r_e         <= {IW{1'b0}};
         r_idx       <= {IW{1'b0}};
         r_acc       <= {W{1'b0}};
         r_op        <= 2'b00;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= {W{1'b0}};
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_in_ready <= (w_state_nxt == S_LOAD);
         r_busy     <= (w_state_nxt == S_CALC) || (w_state_nxt == S_OUT);
         case (r_state)
            S_LOAD: begin
               if (w_in_fire) begin
                  if (r_beat == {BW{1'b0}}) begin
                     r_op <= op_i;
                  end
                  r_beat <= w_load_last ? {BW{1'b0}} : (r_beat + BW'(1));
               end
            end
            S_CALC: begin
               if (w_is_mul) begin
                  r_acc <= w_sum;
                  if (w_k_last) begin
                     r_k <= {CW{1'b0}};
                     if (w_j_last) begin
                        r_j <= {CW{1'b0}};
                        r_i <= w_i_last ? {CW{1'b0}} : (r_i + CW'(1));
                     end else begin
                        r_j <= r_j + CW'(1);
                     end
                  end else begin
                     r_k <= r_k + CW'(1);
                  end
               end else begin
                  r_e <= w_e_last ? {IW{1'b0}} : (r_e + IW'(1));
               end
            end
            S_OUT: begin
               // First OUT cycle only presents R[0]; later cycles advance on handshakes
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= r_mat_r[r_idx];
                  r_out_last  <= (r_idx == IW'(NN - 1));
               end else if (w_out_fire) begin
                  if (r_out_last) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_idx       <= {IW{1'b0}};
                  end else begin
                     r_idx      <= w_idx_inc;
                     r_out_data <= r_mat_r[w_idx_inc];
                     r_out_last <= (w_idx_inc == IW'(NN - 1));
                  end
               end
            end
            default: begin
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Matrix and result storage, intentionally not reset
   always_ff @(posedge clk) begin
      if ((r_state == S_LOAD) && w_in_fire) begin
         if (r_beat < BW'(NN)) begin
            r_mat_a[IW'(r_beat)] <= in_data;
         end else begin
            r_mat_b[IW'(r_beat - BW'(NN))] <= in_data;
         end
      end
      if (r_state == S_CALC) begin
         if (w_is_mul) begin
            if (w_k_last) begin
               r_mat_r[w_r_idx] <= w_sum;
            end
         end else begin
            r_mat_r[r_e] <= w_addsub;
         end
      end
   end

endmodule

// File: tb/tb_mat3_stream_engine.sv
// Directed bench for mat3_stream_engine: reset, mul/add/sub results, latency,
// backpressure and reset during load.
module tb_mat3_stream_engine;

   localparam int W  = 17;
   localparam int N  = 3;
   localparam int NN = 9;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   op_i;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_cyc;

   logic [W-1:0] mat_a [NN] = '{17'h1FFFF, 17'd5, 17'd3, 17'd2, 17'd1, 17'd4, 17'd9, 17'd6, 17'd11};
   logic [W-1:0] mat_b [NN] = '{17'd22, 17'd12, 17'd3, 17'd6, 17'd8, 17'd7, 17'd19, 17'd3, 17'd8};
   logic [W-1:0] exp_mul [NN] = '{17'd65, 17'd37, 17'd56, 17'd126, 17'd44, 17'd45, 17'd443, 17'd189, 17'd157};
   logic [W-1:0] exp_add [NN] = '{17'd21, 17'd17, 17'd6, 17'd8, 17'd9, 17'd11, 17'd28, 17'd9, 17'd19};
   logic [W-1:0] exp_sub [NN] = '{17'h1FFE9, 17'h1FFF9, 17'h00000, 17'h1FFFC, 17'h1FFF9,
                                  17'h1FFFD, 17'h1FFF6, 17'h00003, 17'h00003};

   mat3_stream_engine #(.W(W), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_i      (op_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Streams nbeats of A then B; op_i is corrupted on every beat but the first.
   task automatic load(input logic [1:0] op, input int nbeats, input bit gaps, input bit junk);
      for (int b = 0; b < nbeats; b++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
               @(negedge clk);
               in_valid = 1'b0;
               in_data  = 17'h1ABCD;
               op_i     = 2'($urandom_range(0, 3));
            end
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = junk ? 17'h0AAAA : ((b < NN) ? mat_a[b] : mat_b[b - NN]);
         op_i     = (b == 0) ? op : (op ^ 2'b01);
         begin
            int t;
            t = 0;
            while (!in_ready && t < 50) begin
               @(negedge clk);
               t++;
            end
            if (t >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
         end
         @(posedge clk);
         #1;
         last_cyc = cyc;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_first(input string tag, input int exp_lat);
      int t;
      check({tag, "_busy_calc"}, {31'd0, busy}, 32'd1);
      check({tag, "_in_ready_calc"}, {31'd0, in_ready}, 32'd0);
      t = 0;
      while (!out_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_latency"}, cyc - last_cyc, exp_lat);
   endtask

   task automatic recv(input string tag, input logic [W-1:0] exp [NN], input bit stall);
      int idx;
      int budget;
      bit was_stalled;
      logic [W-1:0] held;
      idx = 0;
      budget = 0;
      was_stalled = 1'b0;
      held = '0;
      while (idx < NN && budget < 500) begin
         if (was_stalled) begin
            check({tag, "_stable"}, out_data, held);
            was_stalled = 1'b0;
         end
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid) begin
            check({tag, "_in_ready_out"}, {31'd0, in_ready}, 32'd0);
            if (out_ready) begin
               check($sformatf("%s_data%0d", tag, idx), out_data, exp[idx]);
               check($sformatf("%s_last%0d", tag, idx), {31'd0, out_last}, (idx == NN - 1) ? 32'd1 : 32'd0);
               idx++;
            end else begin
               held = out_data;
               was_stalled = 1'b1;
            end
         end
         @(negedge clk);
         budget++;
      end
      check({tag, "_count"}, idx, NN);
      out_ready = 1'b0;
      check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      op_i      = 2'b00;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #13;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {15'd0, out_data}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Multiply
      load(2'b00, 2 * NN, 1'b0, 1'b0);
      wait_first("mul", 28);
      recv("mul", exp_mul, 1'b0);

      // Add, then asynchronous reset while the first result is presented
      load(2'b01, 2 * NN, 1'b0, 1'b0);
      wait_first("add_pre", 10);
      check("pre_rst_data", {15'd0, out_data}, 32'd21);
      #2;
      rst = 1'b1;
      #1;
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_out_data", {15'd0, out_data}, 32'd0);
      check("arst_out_last", {31'd0, out_last}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      load(2'b01, 2 * NN, 1'b0, 1'b0);
      wait_first("add", 10);
      recv("add", exp_add, 1'b0);

      // Subtract (op 11 on later beats must be ignored)
      load(2'b10, 2 * NN, 1'b0, 1'b0);
      wait_first("sub", 10);
      recv("sub", exp_sub, 1'b0);

      // Backpressure on both streams, 11 also decodes as multiply
      load(2'b11, 2 * NN, 1'b1, 1'b0);
      wait_first("bp_mul", 28);
      recv("bp_mul", exp_mul, 1'b1);

      // Reset after ten junk beats, then a clean add load
      load(2'b00, 10, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_load_rst_ready", {31'd0, in_ready}, 32'd1);
      load(2'b01, 2 * NN, 1'b1, 1'b0);
      wait_first("add2", 10);
      recv("add2", exp_add, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
